// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin arbiter in front of an 8N1 UART
// transmitter. A byte is accepted only while the transmitter is idle. It is
// then shifted out LSB first as one start bit, eight data bits and one stop bit.
// Each bit lasts CLKS_PER_BIT clock cycles.
//
// Handshake (both requesters): a byte transfers in the cycle where VALID=1 and
// READY=1. READY is combinational and is high only in IDLE, only for the
// requester that wins arbitration, and never during RST. At most one READY is
// high in any cycle. DATA is sampled only in the transfer cycle.
module uart_tx_arbiter #(
    // Clock cycles per UART bit; legal range 2..65535 (fits the 16-bit counter)
    parameter int CLKS_PER_BIT = 416
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_DATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_DATA,
    output logic       REQ1_READY,
    output logic       UART_TXD,
    output logic       BUSY,
    output logic       GRANT_ID,
    output logic [1:0] DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int              CNT_W     = 16;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             txd_q;
    logic             grant_q;
    // Id of the last granted requester; reset to 1 so requester 0 wins the
    // first contention after reset.
    logic             last_grant;

    logic             grant_any;
    logic             grant_sel;
    logic [7:0]       grant_data;
    logic             baud_done;

    // Arbitration: a single valid requester wins. When both are valid, the
    // requester that was not granted last time wins. Nothing is granted
    // outside IDLE or during reset.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (!RST && state == IDLE) begin
            if (REQ0_VALID && REQ1_VALID) begin
                grant_any = 1'b1;
                grant_sel = ~last_grant;
            end else if (REQ0_VALID) begin
                grant_any = 1'b1;
                grant_sel = 1'b0;
            end else if (REQ1_VALID) begin
                grant_any = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign REQ0_READY = grant_any && !grant_sel;
    assign REQ1_READY = grant_any &&  grant_sel;
    assign grant_data = grant_sel ? REQ1_DATA : REQ0_DATA;
    assign baud_done  = (baud_cnt == BAUD_LAST);

    assign UART_TXD  = txd_q;
    assign GRANT_ID  = grant_q;
    assign BUSY      = (state != IDLE);
    assign DBG_STATE = state;

    // Frame sequencer. The line level is registered, so the value driven in a
    // state is set up on the edge that enters that state (or enters that bit).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            txd_q      <= 1'b1;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (grant_any) begin
                        shift_reg  <= grant_data;
                        grant_q    <= grant_sel;
                        last_grant <= grant_sel;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        txd_q      <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd_q    <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd_q     <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter at CLKS_PER_BIT=4. A cycle-level reference model
// predicts READY, BUSY, GRANT_ID and the line level. An independent line
// receiver decodes frames and pops the expected bytes from a scoreboard queue.
module tb_uart_tx_arbiter;

    localparam int C = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ0_VALID = 1'b0;
    logic [7:0] REQ0_DATA = 8'h00;
    logic       REQ1_VALID = 1'b0;
    logic [7:0] REQ1_DATA = 8'h00;
    logic       REQ0_READY;
    logic       REQ1_READY;
    logic       UART_TXD;
    logic       BUSY;
    logic       GRANT_ID;
    logic [1:0] DBG_STATE;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit checks_on = 1'b0;

    // Expected frames: {requester id, byte}
    logic [8:0] exp_q[$];

    uart_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .UART_TXD(UART_TXD), .BUSY(BUSY), .GRANT_ID(GRANT_ID), .DBG_STATE(DBG_STATE)
    );

    // Clock
    always #5 CLK = ~CLK;

    function automatic void check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endfunction

    function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: a frame is a 10-entry bit list starting the cycle after
    // the handshake. Each entry lasts C cycles. Outside a frame the line idles.
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    logic [9:0] m_bits = '1;
    logic       m_last = 1'b1;
    logic       m_grant = 1'b0;

    always @(negedge CLK) begin
        int   off;
        logic e_r0, e_r1, e_txd, w;
        logic [7:0] d;
        off = cyc - m_t0;
        if (m_active && off >= 10 * C) m_active = 1'b0;
        e_txd = m_active ? m_bits[off / C] : 1'b1;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!RST && !m_active) begin
            if (REQ0_VALID && REQ1_VALID) begin
                if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
            end else if (REQ0_VALID) e_r0 = 1'b1;
            else if (REQ1_VALID) e_r1 = 1'b1;
        end
        if (checks_on) begin
            check1("req0_ready", REQ0_READY, e_r0);
            check1("req1_ready", REQ1_READY, e_r1);
            check1("busy", BUSY, m_active);
            check1("uart_txd", UART_TXD, e_txd);
            check1("grant_id", GRANT_ID, m_grant);
        end
        if (RST) begin
            // An aborted frame that the receiver has not yet decoded is dropped.
            if (m_active && off <= 9 * C + C / 2 && exp_q.size() > 0) void'(exp_q.pop_back());
            m_active = 1'b0;
            m_last = 1'b1;
            m_grant = 1'b0;
            checks_on = 1'b1;
        end else if (e_r0 || e_r1) begin
            w = e_r1;
            d = w ? REQ1_DATA : REQ0_DATA;
            m_active = 1'b1;
            m_t0 = cyc + 1;
            m_bits = {1'b1, d, 1'b0};
            m_last = w;
            m_grant = w;
            exp_q.push_back({w, d});
        end
        cyc++;
    end

    // Receiver helpers: wait n cycles, flagging any reset seen on the way.
    task automatic wait_neg(input int n, output bit ab);
        ab = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            if (RST) ab = 1'b1;
        end
    endtask

    task automatic receive_frame();
        logic [7:0] b;
        logic [8:0] e;
        bit ab;
        b = '0;
        wait_neg(C / 2, ab);
        if (ab) return;
        check1("rx_start_bit", UART_TXD, 1'b0);
        for (int k = 0; k < 8; k++) begin
            wait_neg(C, ab);
            if (ab) return;
            b[k] = UART_TXD;
        end
        wait_neg(C, ab);
        if (ab) return;
        check1("rx_stop_bit", UART_TXD, 1'b1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_unexpected_frame cyc=%0d actual=%h expected=none", cyc, b);
        end else begin
            e = exp_q.pop_front();
            check8("rx_frame_data", b, e[7:0]);
            check1("rx_frame_grant", GRANT_ID, e[8]);
        end
    endtask

    // Monitor: start-bit detection on the line, then a mid-bit sampling decode.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (checks_on && !RST && UART_TXD === 1'b0) receive_frame();
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input bit id, input logic [7:0] d);
        bit done;
        done = 1'b0;
        if (id) begin REQ1_VALID = 1'b1; REQ1_DATA = d; end
        else    begin REQ0_VALID = 1'b1; REQ0_DATA = d; end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            done = id ? REQ1_READY : REQ0_READY;
            @(posedge CLK);
            #1;
        end
        if (id) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout cyc=%0d actual=no_ready expected=ready req=%0d", cyc, id);
        end
    endtask

    // Stimulus
    initial begin : stimulus
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(2);

        // Single 0x55 frame from requester 0
        send(1'b0, 8'h55);
        tick(45);

        // Both requesters held valid from reset: alternating frames
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        REQ0_DATA = 8'hA1;
        REQ1_DATA = 8'hB2;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        tick(41 * 4 + 3);
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        tick(45);

        // Requester 1 arrives mid-frame and waits for the first idle cycle
        send(1'b0, 8'h12);
        tick(10);
        send(1'b1, 8'h3C);
        tick(45);

        // Reset in the middle of a 0x00 frame, then contention
        send(1'b0, 8'h00);
        tick(14);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        REQ1_DATA = 8'h7E;
        REQ1_VALID = 1'b1;
        send(1'b0, 8'h81);
        send(1'b1, 8'h7E);
        tick(45);

        // One-cycle VALID pulse while busy must not produce a frame
        send(1'b0, 8'h5A);
        tick(8);
        REQ0_DATA = 8'hEE;
        REQ0_VALID = 1'b1;
        tick(1);
        REQ0_VALID = 1'b0;
        tick(45);

        // All-ones byte from requester 1
        send(1'b1, 8'hFF);
        tick(45);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) REQ0_VALID = ~REQ0_VALID;
            if ($urandom_range(0, 3) == 0) REQ1_VALID = ~REQ1_VALID;
            if ($urandom_range(0, 7) == 0) REQ0_DATA = 8'($urandom);
            if ($urandom_range(0, 7) == 0) REQ1_DATA = 8'($urandom);
            RST = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        RST = 1'b0;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        tick(50);

        // Every expected frame must have been received
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drained actual=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
